// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: VGA scan-out reads take every even-column active cycle,
// remaining cycles carry clear-engine writes or queued draw writes.
module vga_fb_arbiter #(
  parameter int FB_W       = 320,
  parameter int FB_H       = 240,
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        vga_row,
  input  logic [9:0]        vga_col,
  input  logic              vga_rd_n,
  output logic [11:0]       pixel_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [8:0]        wr_x,
  input  logic [7:0]        wr_y,
  input  logic [11:0]       wr_color,
  input  logic              clr_start,
  input  logic [11:0]       clr_color,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [11:0]       mem_wdata,
  input  logic [11:0]       mem_rdata
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;
  state_t state, state_next;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [8:0] x, input logic [7:0] y);
    return ADDR_W'(y) * ADDR_W'(FB_W) + ADDR_W'(x);
  endfunction

  logic              read_slot, in_range, push, pop, clr_wr;
  logic              fifo_empty, fifo_full, rd_pend, unused_ok;
  logic [ADDR_W-1:0] disp_addr, clr_addr, clr_addr_next;
  logic [11:0]       clr_col;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [11:0]       fifo_data [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [PW:0]       count;

  assign unused_ok  = vga_row[0];
  assign read_slot  = !vga_rd_n && !vga_col[0];
  assign disp_addr  = pix_addr(vga_col[9:1], vga_row[8:1]);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
  assign in_range   = (int'(wr_x) < FB_W) && (int'(wr_y) < FB_H);

  // Draw handshake: a transfer happens on a cycle where wr_valid && wr_ready;
  // wr_ready never depends on wr_valid, and out-of-range transfers complete but are dropped.
  assign wr_ready = !fifo_full && (state != DRAIN);
  assign push     = wr_valid && wr_ready && in_range;
  assign clr_busy = (state != IDLE);

  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    clr_wr        = 1'b0;
    pop           = 1'b0;
    if (!read_slot) begin
      if (state == CLEAR) clr_wr = 1'b1;
      else if (!fifo_empty) pop = 1'b1;
    end
    case (state)
      IDLE: if (clr_start) begin
        state_next    = fifo_empty ? CLEAR : DRAIN;
        clr_addr_next = '0;
      end
      DRAIN: if (fifo_empty) state_next = CLEAR;
      CLEAR: if (clr_wr) begin
        clr_addr_next = clr_addr + ADDR_W'(1);
        if (clr_addr == LAST_ADDR) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      clr_addr <= '0;
      clr_col  <= '0;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
      if (state == IDLE && clr_start) clr_col <= clr_color;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= pix_addr(wr_x, wr_y);
      fifo_data[wr_ptr] <= wr_color;
    end
  end

  // rd_pend travels one edge behind the address, so pixel_data captures exactly the read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      rd_pend    <= 1'b0;
      pixel_data <= '0;
    end else begin
      rd_pend <= read_slot;
      mem_we  <= clr_wr | pop;
      if (rd_pend) pixel_data <= mem_rdata;
      if (read_slot) begin
        mem_addr <= disp_addr;
      end else if (clr_wr) begin
        mem_addr  <= clr_addr;
        mem_wdata <= clr_col;
      end else if (pop) begin
        mem_addr  <= fifo_addr[rd_ptr];
        mem_wdata <= fifo_data[rd_ptr];
      end
    end
  end

endmodule
